// File: rtl/axi_ram_slave_if.sv
// AXI channel bundle (ar/r/aw/w/b) between the CPU-side initiator and the RAM responder.
interface axi_ram_slave_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );
endinterface

// File: rtl/axi_ram_slave.sv
// AXI RAM responder: independent read/write burst FSMs over one 32-bit word array.
// Optional read/write wait states are enabled by defining AXI_SLV_WAIT_EN.
module axi_ram_slave #(
  parameter int          ADDR_W    = 14,
  parameter logic [31:0] BASE_ADDR = 32'h1fc0_0000,
  parameter              INIT_FILE = "",
  parameter int          READ_WAIT = 2
) (
  input  logic            clk,
  input  logic            rst,
  axi_ram_slave_if.slave  s
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

`ifdef AXI_SLV_WAIT_EN
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_DATA, W_RESP} w_state_t;
`else
  typedef enum logic [1:0] {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  localparam int unused_read_wait = READ_WAIT;
`endif

  logic [31:0] mem [DEPTH];

  function automatic logic addr_hit(input logic [31:0] a);
    return a[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2];
  endfunction

  function automatic logic [ADDR_W-1:0] widx(input logic [31:0] a);
    return a[ADDR_W+1:2];
  endfunction

  // WRAP is treated like INCR; FIXED keeps the start address for every beat.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + (32'd1 << size);
  endfunction

  // ---------------- read path ----------------
  r_state_t    r_state;
  logic [31:0] r_addr, r_nxt;
  logic [7:0]  r_len, r_cnt;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic        r_hit;
  logic        rvalid_q, rlast_q;
  logic [3:0]  rid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
`ifdef AXI_SLV_WAIT_EN
  logic [7:0]  r_wcnt;
`endif

  assign r_nxt = next_addr(r_addr, r_size, r_burst);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= R_IDLE;
      r_addr   <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_size   <= '0;
      r_burst  <= '0;
      r_hit    <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
      rresp_q  <= '0;
`ifdef AXI_SLV_WAIT_EN
      r_wcnt   <= '0;
`endif
    end else begin
      case (r_state)
        R_IDLE: if (s.arvalid) begin
          rid_q   <= s.arid;
          r_addr  <= s.araddr;
          r_len   <= s.arlen;
          r_size  <= s.arsize;
          r_burst <= s.arburst;
          r_cnt   <= '0;
          r_hit   <= addr_hit(s.araddr);
          rresp_q <= addr_hit(s.araddr) ? RESP_OKAY : RESP_DECERR;
          rlast_q <= (s.arlen == 8'd0);
          rdata_q <= addr_hit(s.araddr) ? mem[widx(s.araddr)] : '0;
`ifdef AXI_SLV_WAIT_EN
          if (READ_WAIT != 0) begin
            r_wcnt  <= '0;
            r_state <= R_WAIT;
          end else begin
            rvalid_q <= 1'b1;
            r_state  <= R_DATA;
          end
`else
          rvalid_q <= 1'b1;
          r_state  <= R_DATA;
`endif
        end
`ifdef AXI_SLV_WAIT_EN
        // Re-fetch on exit so writes landing during the wait are visible.
        R_WAIT: if (int'(r_wcnt) == READ_WAIT - 1) begin
          rvalid_q <= 1'b1;
          rdata_q  <= r_hit ? mem[widx(r_addr)] : '0;
          r_state  <= R_DATA;
        end else begin
          r_wcnt <= r_wcnt + 8'd1;
        end
`endif
        R_DATA: if (s.rready) begin
          if (r_cnt == r_len) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            r_state  <= R_IDLE;
          end else begin
            r_cnt   <= r_cnt + 8'd1;
            r_addr  <= r_nxt;
            rdata_q <= r_hit ? mem[widx(r_nxt)] : '0;
            rlast_q <= ((r_cnt + 8'd1) == r_len);
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign s.arready = ~rst & (r_state == R_IDLE);
  assign s.rvalid  = rvalid_q;
  assign s.rlast   = rlast_q;
  assign s.rid     = rid_q;
  assign s.rdata   = rdata_q;
  assign s.rresp   = rresp_q;

  // ---------------- write path ----------------
  w_state_t    w_state;
  logic [31:0] w_addr;
  logic [7:0]  w_len, w_cnt;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic        w_hit, w_err, w_last_bad, mem_we;
  logic        bvalid_q;
  logic [3:0]  bid_q;
  logic [1:0]  bresp_q;
`ifdef AXI_SLV_WAIT_EN
  logic [7:0]  w_wcnt;
`endif

  assign w_last_bad = s.wlast != (w_cnt == w_len);

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state  <= W_IDLE;
      w_addr   <= '0;
      w_len    <= '0;
      w_cnt    <= '0;
      w_size   <= '0;
      w_burst  <= '0;
      w_hit    <= 1'b0;
      w_err    <= 1'b0;
      bvalid_q <= 1'b0;
      bid_q    <= '0;
      bresp_q  <= '0;
`ifdef AXI_SLV_WAIT_EN
      w_wcnt   <= '0;
`endif
    end else begin
      case (w_state)
        W_IDLE: if (s.awvalid) begin
          bid_q   <= s.awid;
          w_addr  <= s.awaddr;
          w_len   <= s.awlen;
          w_size  <= s.awsize;
          w_burst <= s.awburst;
          w_cnt   <= '0;
          w_hit   <= addr_hit(s.awaddr);
          w_err   <= 1'b0;
`ifdef AXI_SLV_WAIT_EN
          if (READ_WAIT != 0) begin
            w_wcnt  <= '0;
            w_state <= W_WAIT;
          end else begin
            w_state <= W_DATA;
          end
`else
          w_state <= W_DATA;
`endif
        end
`ifdef AXI_SLV_WAIT_EN
        W_WAIT: if (int'(w_wcnt) == READ_WAIT - 1) w_state <= W_DATA;
                else w_wcnt <= w_wcnt + 8'd1;
`endif
        // Burst length is governed by awlen alone; a misplaced wlast only flags SLVERR.
        W_DATA: if (s.wvalid) begin
          if (w_cnt == w_len) begin
            bvalid_q <= 1'b1;
            bresp_q  <= !w_hit               ? RESP_DECERR :
                        (w_err | w_last_bad) ? RESP_SLVERR : RESP_OKAY;
            w_state  <= W_RESP;
          end else begin
            w_cnt  <= w_cnt + 8'd1;
            w_addr <= next_addr(w_addr, w_size, w_burst);
            w_err  <= w_err | w_last_bad;
          end
        end
        W_RESP: if (s.bready) begin
          bvalid_q <= 1'b0;
          w_state  <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign mem_we = ~rst & (w_state == W_DATA) & s.wvalid & w_hit;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (s.wstrb[b]) mem[widx(w_addr)][8*b +: 8] <= s.wdata[8*b +: 8];
      end
    end
  end

  assign s.awready = ~rst & (w_state == W_IDLE);
  assign s.wready  = ~rst & (w_state == W_DATA);
  assign s.bvalid  = bvalid_q;
  assign s.bid     = bid_q;
  assign s.bresp   = bresp_q;

  logic unused_sideband;
  assign unused_sideband = ^{s.arlock, s.arcache, s.arprot, s.awlock, s.awcache, s.awprot, s.wid};
endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: per-beat scoreboard from a flat memory model plus literal pins.
module tb_axi_ram_slave;
  localparam int          ADDR_W = 14;
  localparam logic [31:0] BASE   = 32'h1fc0_0000;
`ifdef AXI_SLV_WAIT_EN
  localparam int RLAT = 3;
`else
  localparam int RLAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_ram_slave_if ifc();
  axi_ram_slave #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .INIT_FILE(""), .READ_WAIT(2))
    dut (.clk(clk), .rst(rst), .s(ifc));

  typedef struct { logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id; } rbeat_t;
  typedef struct { logic [1:0] resp; logic [3:0] id; } bexp_t;

  rbeat_t      rq[$];
  bexp_t       bq[$];
  logic [31:0] mm [int];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic [31:0] got [256];
  logic        got_last [256];
  logic [1:0]  got_resp [256];
  logic [1:0]  last_bresp;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  function automatic logic in_region(input logic [31:0] a);
    return (a >> (ADDR_W + 2)) == (BASE >> (ADDR_W + 2));
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int k,
                                            input logic [2:0] size, input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + 32'(k) * (32'd1 << size);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) & 32'((1 << ADDR_W) - 1));
  endfunction

  // Scoreboard: every visible R/B beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst) begin
      rq.delete();
      bq.delete();
    end else begin
      if (ifc.rvalid) begin
        if (rq.size() == 0) fail_now("r_unexpected_beat");
        else begin
          chk("rdata", ifc.rdata, rq[0].data);
          chk("rresp", 32'(ifc.rresp), 32'(rq[0].resp));
          chk("rlast", 32'(ifc.rlast), 32'(rq[0].last));
          chk("rid",   32'(ifc.rid),   32'(rq[0].id));
          if (ifc.rready) void'(rq.pop_front());
        end
      end
      if (ifc.bvalid) begin
        if (bq.size() == 0) fail_now("b_unexpected");
        else begin
          chk("bresp", 32'(ifc.bresp), 32'(bq[0].resp));
          chk("bid",   32'(ifc.bid),   32'(bq[0].id));
          if (ifc.bready) void'(bq.pop_front());
        end
      end
    end
  end

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int last_beat, input bit early);
    logic        hit;
    logic [31:0] a, cur;
    bexp_t       e;
    int          c;
    hit = in_region(addr);
    for (int k = 0; k <= int'(len); k++) begin
      a = beat_addr(addr, k, size, burst);
      if (hit) begin
        cur = mm.exists(word_of(a)) ? mm[word_of(a)] : 32'h0;
        for (int b = 0; b < 4; b++) if (ws[k][b]) cur[8*b +: 8] = wd[k][8*b +: 8];
        mm[word_of(a)] = cur;
      end
    end
    e.id   = id;
    e.resp = !hit ? 2'b11 : (last_beat != int'(len)) ? 2'b10 : 2'b00;
    bq.push_back(e);

    @(posedge clk); #1;
    if (early) begin
      ifc.wvalid = 1'b1; ifc.wdata = wd[0]; ifc.wstrb = ws[0]; ifc.wlast = (last_beat == 0);
      repeat (2) begin
        @(negedge clk);
        chk("w_stall_before_aw", 32'(ifc.wready), 32'd0);
      end
      @(posedge clk); #1;
    end
    ifc.awid = id; ifc.awaddr = addr; ifc.awlen = len; ifc.awsize = size; ifc.awburst = burst;
    ifc.awvalid = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; end while (!ifc.awready && c < 50);
    if (!ifc.awready) begin fail_now("aw_timeout"); ifc.awvalid = 1'b0; return; end
    @(posedge clk); #1;
    ifc.awvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      ifc.wvalid = 1'b1; ifc.wdata = wd[k]; ifc.wstrb = ws[k]; ifc.wlast = (k == last_beat);
      c = 0;
      do begin @(negedge clk); c++; end while (!ifc.wready && c < 50);
      if (!ifc.wready) begin fail_now("w_timeout"); ifc.wvalid = 1'b0; return; end
      @(posedge clk); #1;
    end
    ifc.wvalid = 1'b0; ifc.wlast = 1'b0;
    @(negedge clk);
    chk("b_latency", 32'(ifc.bvalid), 32'd1);
    c = 0;
    while (!(ifc.bvalid && ifc.bready) && c < 50) begin @(negedge clk); c++; end
    if (!ifc.bvalid) begin fail_now("b_timeout"); return; end
    last_bresp = ifc.bresp;
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input bit toggle, input int stop_after);
    logic        hit;
    logic [31:0] a;
    rbeat_t      e;
    int          c, nb, first;
    hit = in_region(addr);
    for (int k = 0; k <= int'(len); k++) begin
      a      = beat_addr(addr, k, size, burst);
      e.data = hit ? mm[word_of(a)] : 32'h0;
      e.resp = hit ? 2'b00 : 2'b11;
      e.last = (k == int'(len));
      e.id   = id;
      rq.push_back(e);
    end

    @(posedge clk); #1;
    ifc.arid = id; ifc.araddr = addr; ifc.arlen = len; ifc.arsize = size; ifc.arburst = burst;
    ifc.arvalid = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; end while (!ifc.arready && c < 50);
    if (!ifc.arready) begin fail_now("ar_timeout"); ifc.arvalid = 1'b0; return; end
    @(posedge clk); #1;
    ifc.arvalid = 1'b0;
    nb = 0; first = 0; c = 0;
    while (nb < stop_after && c < 1000) begin
      ifc.rready = toggle ? (c % 2 == 1) : 1'b1;
      @(negedge clk); c++;
      if (ifc.rvalid && first == 0) first = c;
      if (ifc.rvalid && ifc.rready) begin
        got[nb] = ifc.rdata; got_last[nb] = ifc.rlast; got_resp[nb] = ifc.rresp;
        nb++;
      end
      @(posedge clk); #1;
    end
    ifc.rready = 1'b0;
    chk("r_latency", 32'(first), 32'(RLAT));
    chk("r_beat_count", 32'(nb), 32'(stop_after));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.arid = '0; ifc.araddr = '0; ifc.arlen = '0; ifc.arsize = '0; ifc.arburst = '0;
    ifc.arlock = '0; ifc.arcache = '0; ifc.arprot = '0; ifc.arvalid = 1'b0; ifc.rready = 1'b0;
    ifc.awid = '0; ifc.awaddr = '0; ifc.awlen = '0; ifc.awsize = '0; ifc.awburst = '0;
    ifc.awlock = '0; ifc.awcache = '0; ifc.awprot = '0; ifc.awvalid = 1'b0;
    ifc.wid = '0; ifc.wdata = '0; ifc.wstrb = '0; ifc.wlast = 1'b0; ifc.wvalid = 1'b0;
    ifc.bready = 1'b1;
    for (int i = 0; i < 256; i++) begin wd[i] = '0; ws[i] = 4'hf; end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", 32'(ifc.arready), 32'd0);
    chk("rst_awready", 32'(ifc.awready), 32'd0);
    chk("rst_wready",  32'(ifc.wready),  32'd0);
    chk("rst_rvalid",  32'(ifc.rvalid),  32'd0);
    chk("rst_rlast",   32'(ifc.rlast),   32'd0);
    chk("rst_bvalid",  32'(ifc.bvalid),  32'd0);
    chk("rst_rdata",   ifc.rdata,        32'd0);
    chk("rst_rid",     32'(ifc.rid),     32'd0);
    chk("rst_rresp",   32'(ifc.rresp),   32'd0);
    chk("rst_bid",     32'(ifc.bid),     32'd0);
    chk("rst_bresp",   32'(ifc.bresp),   32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_arready", 32'(ifc.arready), 32'd1);
    chk("idle_awready", 32'(ifc.awready), 32'd1);
    chk("idle_wready",  32'(ifc.wready),  32'd0);

    // single-beat write then read of word 2
    wd[0] = 32'hdead_beef; ws[0] = 4'hf;
    axi_write(4'd1, BASE + 32'd8, 8'd0, 3'd2, 2'b01, 0, 1'b0);
    chk("lit_bresp_okay", 32'(last_bresp), 32'd0);
    axi_read(4'd3, BASE + 32'd8, 8'd0, 3'd2, 2'b01, 1'b0, 1);
    chk("lit_word2", got[0], 32'hdead_beef);
    chk("lit_word2_last", 32'(got_last[0]), 32'd1);

    // 4-beat INCR burst, W offered before AW
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hf; end
    axi_write(4'd5, BASE + 32'd4, 8'd3, 3'd2, 2'b01, 3, 1'b1);
    chk("lit_burst_bresp", 32'(last_bresp), 32'd0);
    axi_read(4'd6, BASE + 32'd4, 8'd3, 3'd2, 2'b01, 1'b0, 4);
    chk("lit_burst_b0", got[0], 32'd1);
    chk("lit_burst_b3", got[3], 32'd4);
    chk("lit_burst_last2", 32'(got_last[2]), 32'd0);
    chk("lit_burst_last3", 32'(got_last[3]), 32'd1);

    // byte strobe merge
    wd[0] = 32'h1122_3344; ws[0] = 4'hf;
    axi_write(4'd2, BASE + 32'd40, 8'd0, 3'd2, 2'b01, 0, 1'b0);
    wd[0] = 32'h0000_ab00; ws[0] = 4'b0010;
    axi_write(4'd2, BASE + 32'd40, 8'd0, 3'd2, 2'b01, 0, 1'b0);
    axi_read(4'd4, BASE + 32'd40, 8'd0, 3'd2, 2'b01, 1'b0, 1);
    chk("lit_strobe_merge", got[0], 32'h1122_ab44);

    // out-of-region read with rready toggling
    axi_read(4'd7, 32'h0000_0000, 8'd1, 3'd2, 2'b01, 1'b1, 2);
    chk("lit_decerr_data", got[1], 32'd0);
    chk("lit_decerr_resp", 32'(got_resp[1]), 32'd3);

    // out-of-region write must not touch the aliased word
    wd[0] = 32'h5555_5555; ws[0] = 4'hf;
    axi_write(4'd8, BASE + 32'h40, 8'd0, 3'd2, 2'b01, 0, 1'b0);
    wd[0] = 32'hffff_ffff;
    axi_write(4'd9, 32'h0000_0040, 8'd0, 3'd2, 2'b01, 0, 1'b0);
    chk("lit_decerr_bresp", 32'(last_bresp), 32'd3);
    axi_read(4'd1, BASE + 32'h40, 8'd0, 3'd2, 2'b01, 1'b0, 1);
    chk("lit_decerr_discard", got[0], 32'h5555_5555);

    // early wlast on beat 1 of a 3-beat burst
    for (int i = 0; i < 3; i++) begin wd[i] = 32'hc0de_0000 + 32'(i); ws[i] = 4'hf; end
    axi_write(4'd10, BASE + 32'h80, 8'd2, 3'd2, 2'b01, 1, 1'b0);
    chk("lit_slverr", 32'(last_bresp), 32'd2);
    axi_read(4'd11, BASE + 32'h80, 8'd2, 3'd2, 2'b01, 1'b0, 3);
    chk("lit_slverr_b2", got[2], 32'hc0de_0002);

    // FIXED burst keeps hitting one word
    wd[0] = 32'haaaa_0001; wd[1] = 32'hbbbb_0002; wd[2] = 32'hcccc_0003;
    for (int i = 0; i < 3; i++) ws[i] = 4'hf;
    axi_write(4'd12, BASE + 32'h100, 8'd2, 3'd2, 2'b00, 2, 1'b0);
    axi_read(4'd13, BASE + 32'h100, 8'd1, 3'd2, 2'b00, 1'b0, 2);
    chk("lit_fixed_b1", got[1], 32'hcccc_0003);

    // halfword WRAP burst then narrow read returns whole word
    wd[0] = 32'h0000_1111; ws[0] = 4'b0011;
    wd[1] = 32'h2222_0000; ws[1] = 4'b1100;
    axi_write(4'd14, BASE + 32'h200, 8'd1, 3'd1, 2'b10, 1, 1'b0);
    axi_read(4'd15, BASE + 32'h201, 8'd0, 3'd0, 2'b01, 1'b0, 1);
    chk("lit_narrow", got[0], 32'h2222_1111);

    // reset in the middle of a read burst
    for (int i = 0; i < 8; i++) begin wd[i] = 32'h7000_0000 + 32'(i); ws[i] = 4'hf; end
    axi_write(4'd6, BASE + 32'h300, 8'd7, 3'd2, 2'b01, 7, 1'b0);
    axi_read(4'd6, BASE + 32'h300, 8'd7, 3'd2, 2'b01, 1'b0, 2);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_arready", 32'(ifc.arready), 32'd0);
    @(negedge clk);
    chk("midrst_rvalid", 32'(ifc.rvalid), 32'd0);
    chk("midrst_rlast",  32'(ifc.rlast),  32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_arready_after", 32'(ifc.arready), 32'd1);
    axi_read(4'd2, BASE + 32'h304, 8'd0, 3'd2, 2'b01, 1'b0, 1);
    chk("lit_after_reset", got[0], 32'h7000_0001);

    repeat (3) @(negedge clk);
    if (rq.size() != 0 || bq.size() != 0) fail_now("scoreboard_not_drained");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
